// File: rtl/uart_rx_bit_sampler.sv
// Oversampling front-end of the UART receiver.
// Runs the per-bit edge counter and the frame bit counter, and recovers each
// serial bit with a 3-sample majority vote taken around mid-bit.
module uart_rx_bit_sampler #(
  parameter int PRESC_W  = 6,
  parameter int BITCNT_W = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                enable,
  input  logic                data_samp_en,
  input  logic                RX_IN,
  input  logic [PRESC_W-1:0]  Prescale,
  output logic [BITCNT_W-1:0] bit_cnt,
  output logic [PRESC_W-1:0]  edge_cnt,
  output logic                sampled_bit,
  output logic                sample_valid
);

  localparam logic [BITCNT_W-1:0] BIT_MAX = {BITCNT_W{1'b1}};

  logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [PRESC_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [2:0]          samp_q, samp_d;      // newest sample in bit 0
  logic [2:0]          flags_q, flags_d;    // [0]=P/2-1, [1]=P/2, [2]=P/2+1 captured
  logic                sampled_bit_q, sampled_bit_d;
  logic                sample_valid_q, sample_valid_d;

  logic [PRESC_W-1:0]  ratio;
  logic [PRESC_W-1:0]  last_edge;
  logic [PRESC_W-1:0]  half;
  logic [PRESC_W-1:0]  samp_lo, samp_mid, samp_hi, vote_pt;
  logic                majority;

  // Decode the effective ratio; anything other than 16 or 32 runs as 8.
  always_comb begin
    if (Prescale == PRESC_W'(16))      ratio = PRESC_W'(16);
    else if (Prescale == PRESC_W'(32)) ratio = PRESC_W'(32);
    else                               ratio = PRESC_W'(8);
    last_edge = ratio - PRESC_W'(1);
    half      = ratio >> 1;
    samp_lo   = half - PRESC_W'(1);
    samp_mid  = half;
    samp_hi   = half + PRESC_W'(1);
    vote_pt   = half + PRESC_W'(2);
  end

  // Edge and bit counters; the enable-raise cycle already counts as edge 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!enable) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (bit_cnt_q == '0) begin
      bit_cnt_d  = BITCNT_W'(1);
      edge_cnt_d = PRESC_W'(1);
    end else if (edge_cnt_q == last_edge) begin
      edge_cnt_d = '0;
      if (bit_cnt_q != BIT_MAX) bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
    end else begin
      edge_cnt_d = edge_cnt_q + PRESC_W'(1);
    end
  end

  assign majority = (samp_q[2] & samp_q[1]) | (samp_q[1] & samp_q[0]) |
                    (samp_q[2] & samp_q[0]);

  // Capture the three mid-bit samples and vote once all three are present.
  always_comb begin
    samp_d         = samp_q;
    flags_d        = flags_q;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    if (!enable || edge_cnt_q == '0) begin
      flags_d = '0;
    end else begin
      if (data_samp_en) begin
        if (edge_cnt_q == samp_lo) begin
          samp_d     = {samp_q[1:0], RX_IN};
          flags_d[0] = 1'b1;
        end
        if (edge_cnt_q == samp_mid) begin
          samp_d     = {samp_q[1:0], RX_IN};
          flags_d[1] = 1'b1;
        end
        if (edge_cnt_q == samp_hi) begin
          samp_d     = {samp_q[1:0], RX_IN};
          flags_d[2] = 1'b1;
        end
      end
      if (edge_cnt_q == vote_pt && (&flags_q)) begin
        sampled_bit_d  = majority;
        sample_valid_d = 1'b1;
      end
    end
  end

  // State register; the line idles high so the sample history resets to ones.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt_q      <= '0;
      edge_cnt_q     <= '0;
      samp_q         <= 3'b111;
      flags_q        <= '0;
      sampled_bit_q  <= 1'b1;
      sample_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      bit_cnt_q      <= bit_cnt_d;
      edge_cnt_q     <= edge_cnt_d;
      samp_q         <= samp_d;
      flags_q        <= flags_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign bit_cnt      = bit_cnt_q;
  assign edge_cnt     = edge_cnt_q;
  assign sampled_bit  = sampled_bit_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Directed bench for uart_rx_bit_sampler: a per-cycle vector table from reset,
// then hand-written multi-cycle sequences for frames, voting, gating, abort,
// saturation and asynchronous reset.
module tb_uart_rx_bit_sampler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       dse;
  logic       rx;
  logic [5:0] presc;
  logic [3:0] bit_cnt;
  logic [5:0] edge_cnt;
  logic       sampled_bit;
  logic       sample_valid;

  int tests_run = 0;
  int tests_failed = 0;
  logic exp_sb;
  int pulses;

  uart_rx_bit_sampler #(.PRESC_W(6), .BITCNT_W(4)) dut (
    .CLK          (clk),
    .RST          (rst_n),
    .enable       (en),
    .data_samp_en (dse),
    .RX_IN        (rx),
    .Prescale     (presc),
    .bit_cnt      (bit_cnt),
    .edge_cnt     (edge_cnt),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       dse;
    logic       rx;
    logic [5:0] presc;
    logic [3:0] exp_bit;
    logic [5:0] exp_edge;
    logic       exp_sb;
    logic       exp_sv;
  } vec_t;

  vec_t vecs[13];

  // Packs outputs as {bit_cnt[3:0], edge_cnt[5:0], sampled_bit, sample_valid}.
  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = {bit_cnt, edge_cnt, sampled_bit, sample_valid};
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got bit=%0d edge=%0d sb=%b sv=%b, want bit=%0d edge=%0d sb=%b sv=%b",
               name, act[11:8], act[7:2], act[1], act[0], exp[11:8], exp[7:2], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle with enable low: counters at zero, no pulse.
  task automatic idle(input string name);
    en  = 1'b0;
    dse = 1'b0;
    rx  = 1'b1;
    step();
    check(name, {4'd0, 6'd0, exp_sb, 1'b0});
  endtask

  // Runs ncyc cycles of bit b at ratio p. pts drives edges p/2-1, p/2, p/2+1
  // (msb first), other drives the rest; dse_mid gates the middle capture.
  task automatic run_bit(input string name, input int p, input int b, input int ncyc,
                         input logic [2:0] pts, input logic other, input logic dse_mid,
                         input logic vote_ok, input logic vote_val);
    int h;
    logic [3:0] eb;
    logic [5:0] ee;
    logic       esv;
    h = p / 2;
    for (int e = 0; e < ncyc; e++) begin
      en  = 1'b1;
      dse = (e == h) ? dse_mid : 1'b1;
      if (e == h - 1)      rx = pts[2];
      else if (e == h)     rx = pts[1];
      else if (e == h + 1) rx = pts[0];
      else                 rx = other;
      step();
      if (e + 1 == p) begin
        ee = 6'd0;
        eb = (b >= 15) ? 4'd15 : 4'(b + 1);
      end else begin
        ee = 6'(e + 1);
        eb = 4'(b);
      end
      esv = (e == h + 2) && vote_ok;
      if (esv) exp_sb = vote_val;
      if (sample_valid) pulses++;
      check(name, {eb, ee, exp_sb, esv});
    end
  endtask

  initial begin
    logic [9:0] frame;
    rst_n = 1'b0; en = 1'b0; dse = 1'b0; rx = 1'b1; presc = 6'd8;
    exp_sb = 1'b1;
    pulses = 0;

    // Reset held with the line toggling, release, then one bit at Prescale=12 (runs as 8).
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd8,  4'd0, 6'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd8,  4'd0, 6'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd12, 4'd0, 6'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 6'd12, 4'd0, 6'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd12, 4'd1, 6'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd12, 4'd1, 6'd2, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd12, 4'd1, 6'd3, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd12, 4'd1, 6'd4, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd12, 4'd1, 6'd5, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd12, 4'd1, 6'd6, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd12, 4'd1, 6'd7, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd12, 4'd2, 6'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'd12, 4'd0, 6'd0, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      rst_n = vecs[i].rst_n;
      en    = vecs[i].en;
      dse   = vecs[i].dse;
      rx    = vecs[i].rx;
      presc = vecs[i].presc;
      step();
      check($sformatf("vec%0d", i),
            {vecs[i].exp_bit, vecs[i].exp_edge, vecs[i].exp_sb, vecs[i].exp_sv});
    end
    exp_sb = 1'b0;

    // Full frame at P=8: start 0, data 1010_0101 sent lsb first, stop 1.
    presc = 6'd8;
    frame = 10'b11_0100_1010;
    pulses = 0;
    for (int i = 0; i < 10; i++)
      run_bit($sformatf("frame_b%0d", i + 1), 8, i + 1, 8, {3{frame[i]}}, frame[i],
              1'b1, 1'b1, frame[i]);
    tests_run++;
    if (pulses != 10) begin
      tests_failed++;
      $display("FAIL frame_pulses: got %0d, want 10", pulses);
    end
    idle("frame_idle");

    // Majority vote at P=16.
    presc = 6'd16;
    run_bit("maj16_101", 16, 1, 16, 3'b101, 1'b0, 1'b1, 1'b1, 1'b1);
    run_bit("maj16_001", 16, 2, 16, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
    idle("maj16_idle");

    // P=32: samples at 15,16,17, wrap 31->0.
    presc = 6'd32;
    run_bit("p32", 32, 1, 32, 3'b011, 1'b0, 1'b1, 1'b1, 1'b1);
    idle("p32_idle");

    // Missing middle capture suppresses the vote; next bit votes normally.
    presc = 6'd8;
    run_bit("gate_off", 8, 1, 8, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_bit("gate_on",  8, 2, 8, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    idle("gate_idle");

    // Abort at edge 3 of bit 4, then abort with a vote pending at edge 6.
    for (int i = 1; i <= 3; i++)
      run_bit("abort_a", 8, i, 8, 3'b111, 1'b1, 1'b1, 1'b1, 1'b1);
    run_bit("abort_a4", 8, 4, 3, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    idle("abort_a_drop");
    for (int i = 1; i <= 3; i++)
      run_bit("abort_b", 8, i, 8, 3'b111, 1'b1, 1'b1, 1'b1, 1'b1);
    run_bit("abort_b4", 8, 4, 6, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    idle("abort_b_drop");
    idle("abort_b_hold");

    // Saturation: 16 bit times, bit_cnt holds at 15.
    for (int i = 1; i <= 16; i++)
      run_bit($sformatf("sat_b%0d", i), 8, (i > 15) ? 15 : i, 8, 3'b111, 1'b1,
              1'b1, 1'b1, 1'b1);
    idle("sat_idle");

    // Asynchronous reset in bit 6, between clock edges.
    for (int i = 1; i <= 5; i++)
      run_bit("rst_pre", 8, i, 8, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    run_bit("rst_b6", 8, 6, 2, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_sb = 1'b1;
    check("rst_async", {4'd0, 6'd0, 1'b1, 1'b0});
    step();
    check("rst_held", {4'd0, 6'd0, 1'b1, 1'b0});
    en = 1'b0;
    #2;
    rst_n = 1'b1;
    idle("rst_release");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_bit_sampler.md
Name: uart_rx_bit_sampler

Overview:
Oversampling front-end of the UART receiver. It runs the per-bit edge counter and the frame bit counter, and recovers each serial bit by a 3-sample majority vote around mid-bit. It sits directly upstream of the receive control FSM: it drives the `bit_cnt` the FSM decodes, and is gated by the FSM's `enable` and `data_samp_en`. The recovered `sampled_bit` and `sample_valid` feed the start, parity and stop checkers and the deserializer.

Parameters:
PRESC_W, 6, width of the Prescale input (legal ratios 8, 16, 32).
BITCNT_W, 4, width of bit_cnt; must hold 0..15.

Ports:
CLK  in  1  oversampling clock (Prescale × baud).
RST  in  1  asynchronous active-low reset.
enable  in  1  counter run enable from the RX FSM.
data_samp_en  in  1  sample capture enable from the RX FSM.
RX_IN  in  1  serial line, already synchronized to CLK.
Prescale  in  PRESC_W  oversampling ratio.
bit_cnt  out  BITCNT_W  frame bit index: 1 = start, 2..9 = data, 10 = parity or stop, 11 = stop with parity.
edge_cnt  out  PRESC_W  oversample index inside the current bit, 0..P-1.
sampled_bit  out  1  majority-voted bit value, registered.
sample_valid  out  1  1-cycle pulse; sampled_bit is updated this cycle.

Behaviour:
- Reset is asynchronous and active-low on RST; clock is CLK, all state updates on its rising edge.
- Reset values: bit_cnt=0, edge_cnt=0, sampled_bit=1 (line idle level), sample_valid=0, sample shift register=3'b111.
- Effective ratio P is decoded from Prescale: 8→8, 16→16, 32→32. Any other value is treated as 8. P is re-decoded every cycle; software changes Prescale only while enable=0.
- Counters, evaluated in priority order:
  - enable=0: edge_cnt←0, bit_cnt←0, next cycle. No sample_valid pulse is issued.
  - enable=1 and bit_cnt=0: bit_cnt←1, edge_cnt←1. The FSM raises enable on the same cycle RX_IN first reads 0, so that cycle counts as edge 0 of the start bit.
  - enable=1 and bit_cnt≠0 and edge_cnt=P-1: edge_cnt←0, bit_cnt←bit_cnt+1. bit_cnt saturates at 15 and never wraps to 0.
  - Otherwise, while enable=1: edge_cnt←edge_cnt+1.
- Sampling (P/2 computed with a shift, no divider):
  - Sample points are edge_cnt = P/2-1, P/2 and P/2+1. At each one, if data_samp_en=1, RX_IN shifts into the 3-bit register and the matching capture flag sets.
  - All capture flags clear when edge_cnt=0 or enable=0.
  - At edge_cnt=P/2+2: if all 3 flags are set, sampled_bit←majority(s2,s1,s0) and sample_valid←1 for exactly one cycle. If any flag is missing, sampled_bit holds and sample_valid stays 0.
  - Latency: sample_valid rises 1 cycle after the edge_cnt=P/2+2 cycle. For P=8 that is the cycle after edge_cnt=6.
- enable falling mid-bit: counters and flags clear next cycle. A pending vote is discarded. sampled_bit holds its last value.
- RST asserted mid-frame: every output returns to its reset value immediately, regardless of CLK.
- enable and data_samp_en both toggling on the same cycle: the counters follow the enable rules; capture follows data_samp_en at the sample point only.
- Outputs are registered only; there is no combinational path from RX_IN to any output.

Test Plan:
- Reset: RST=0 with CLK running and RX_IN toggling → bit_cnt=0, edge_cnt=0, sampled_bit=1, sample_valid=0 throughout. Release RST → values hold until enable=1.
- Full frame, P=8, PAR_EN=0: enable and data_samp_en held high for 10 bit times, serial 0,1010_0101,1 → bit_cnt steps 1..10 at each edge_cnt 7→0 wrap. sample_valid pulses 10 times, each 1 cycle after edge_cnt=6. sampled_bit sequence is 0,1,0,1,0,0,1,0,1,1.
- Majority vote, P=16: RX_IN samples 1,0,1 at edge_cnt 7,8,9 → sampled_bit=1 and sample_valid pulses the cycle after edge_cnt=10. Samples 0,0,1 → sampled_bit=0.
- Illegal and large Prescale: Prescale=12 → edge_cnt wraps 7→0 (P=8). Prescale=32 → wraps 31→0, sample points at 15, 16, 17.
- Capture gating and abort: data_samp_en=0 at edge_cnt=P/2 → no sample_valid pulse for that bit. Drop enable at edge_cnt=3 of bit 4 → next cycle bit_cnt=0, edge_cnt=0, sampled_bit unchanged.
- Saturation and mid-frame reset: keep enable=1 past 15 bit times → bit_cnt holds at 15. Pulse RST low at bit_cnt=6 → all outputs return to reset values asynchronously.
